ram_dp_init: RTL and testbench
==============================

// Module: ram_dp_init
// PURPOSE
//   Simple dual-port cell RAM for the VOQ shared cache: next generation of the plain dual-port RAM.
//   Adds byte-enable writes, a self-clearing init sweep after reset, and a read-valid pipeline.
//   Adds write-first read/write collision bypass and an optional output register stage.
//   Sits under the VOQ queue managers as the cell/pointer store; callers gate traffic on init_done.
// PARAMETERS
//   ADDR_WIDTH  6   address bits; DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH  8   word width; must be a multiple of BYTE_W
//   BYTE_W      8   bits per byte-enable lane; NUM_BE = DATA_WIDTH/BYTE_W
//   INIT_VALUE  0   word written to every address during the init sweep
// PORTS
//   clk       in   1           single clock, rising edge
//   rst_n     in   1           asynchronous, active-low reset
//   wr_en     in   1           write request; accepted only when init_done=1
//   wr_addr   in   ADDR_WIDTH  write address
//   wr_data   in   DATA_WIDTH  write data
//   wr_be     in   NUM_BE      per-lane write enable; lane i covers bits [i*BYTE_W +: BYTE_W]
//   rd_en     in   1           read request; accepted only when init_done=1
//   rd_addr   in   ADDR_WIDTH  read address
//   rd_data   out  DATA_WIDTH  read data; holds its last value when no read completes
//   rd_valid  out  1           one-cycle pulse marking rd_data valid for one accepted read
//   init_done out  1           1 = sweep finished, RAM open for traffic
// BEHAVIOUR
//   Reset values: rd_data=0, rd_valid=0, init_done=0, FSM=S_INIT, sweep counter=0.
//   FSM S_INIT: writes INIT_VALUE to address cnt each cycle, all lanes enabled; cnt increments by 1.
//     On cnt==DEPTH-1 the FSM goes to S_RUN.
//     init_done rises on the edge that writes the last address.
//     The sweep takes exactly DEPTH cycles after rst_n deasserts.
//   FSM S_RUN: terminal state; only rst_n leaves it.
//   In S_INIT, wr_en and rd_en are ignored: no array update, rd_valid stays 0, rd_data holds.
//   Write in S_RUN: for each lane with wr_be[i]=1 the lane is updated at the clk edge; other lanes are kept.
//     wr_be=0 with wr_en=1 is a legal no-op.
//   Read latency, macro off: rd_en at edge N gives rd_data and rd_valid=1 after edge N.
//     rd_valid falls after edge N+1 unless a new read is accepted at that edge.
//     Back-to-back reads give one result per cycle.
//   Collision, write-first: rd_en && wr_en && rd_addr==wr_addr in the same cycle.
//     rd_data = wr_data on lanes with wr_be=1 and old array content on the other lanes.
//     Write then read of the same address in the next cycle returns the new data; no bypass is needed there.
//   Address wrap: addresses are exactly ADDR_WIDTH bits; no out-of-range case exists.
//   Sweep counter: ADDR_WIDTH+1 bits so that DEPTH-1 is detected without wrapping.
//   Reset mid-operation: rst_n low aborts the sweep or any in-flight read at once.
//     Outputs go to reset values; the full sweep restarts from address 0 after release.
// CONFIGURATION
//   RAM_OUT_REG_EN defined: adds one output register after the array read.
//     Read latency becomes 2; rd_valid is delayed in step with the data.
//     Collision merge is captured at stage 1, so it still reflects the write of the request cycle.
//     The stage-2 register also resets to 0.
//   RAM_OUT_REG_EN undefined: latency 1, as described in BEHAVIOUR.
// STRUCTURE
//   Shared header ram_defs.vh holds:
//     FSM state localparams S_INIT=1'b0 and S_RUN=1'b1;
//     the NUM_BE derivation macro;
//     a RAM_RD_LAT constant, 1 or 2, selected by RAM_OUT_REG_EN.
//   Sub-module ram_init_ctrl: FSM plus sweep counter.
//     Outputs init_we, init_addr and init_done.
//     The top level muxes init_* against the user write port.
//   Top level: byte-lane write loop, read pipeline, collision compare and merge.
// TESTING
//   1. Reset release with ADDR_WIDTH=6, INIT_VALUE=8'hA5 -> init_done=0 for 64 cycles, 1 from cycle 64.
//      Reading every address afterwards returns 8'hA5.
//   2. Traffic during the sweep: wr_en and rd_en at cycle 10 -> rd_valid never pulses.
//      Address 10 still reads INIT_VALUE after init.
//   3. DATA_WIDTH=32: write 32'h11223344 to addr 5, then wr_be=4'b0010 with data 32'hFFFFFFFF to addr 5.
//      Read of addr 5 -> 32'h1122FF44, rd_valid pulse 1 cycle after rd_en (2 with RAM_OUT_REG_EN).
//   4. Collision: addr 7 holds 32'h0; same-cycle write 32'hDEADBEEF with be=4'b1100 and read of addr 7.
//      rd_data=32'hDEAD0000.
//   5. Reads of addr 0..3 on 4 consecutive cycles -> 4 consecutive rd_valid pulses, data in order.
//   6. rst_n pulsed low mid-sweep at cycle 30 and mid-read -> rd_valid=0 and init_done=0 at once.
//      The sweep restarts and completes 64 cycles after release.

Source files
------------

// File: rtl/ram_dp_init_pkg.sv
// Shared definitions for the ram_dp_init cell RAM: FSM states, read latency, lane count.
// RAM_RD_LAT follows the optional RAM_OUT_REG_EN output register stage.
package ram_dp_init_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

`ifdef RAM_OUT_REG_EN
    localparam int RAM_RD_LAT = 2;
`else
    localparam int RAM_RD_LAT = 1;
`endif

    function automatic int num_be(input int dataWidth, input int byteW);
        return dataWidth / byteW;
    endfunction

endpackage

// File: rtl/ram_init_ctrl.sv
// Init sweep controller: walks every address once after reset writing the init word,
// then parks in S_RUN and raises init done until the next reset.
module ram_init_ctrl
    import ram_dp_init_pkg::*;
#(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_init_we,
    output logic [ADDR_WIDTH-1:0] o_init_addr,
    output logic                  o_init_done
);

    // One spare counter bit lets the last address be detected without wrapping.
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = {1'b0, {ADDR_WIDTH{1'b1}}};

    state_e                r_state;
    state_e                w_nextState;
    logic   [ADDR_WIDTH:0] r_cnt;
    logic   [ADDR_WIDTH:0] w_nextCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        o_init_we   = 1'b0;
        o_init_addr = r_cnt[ADDR_WIDTH-1:0];
        case (r_state)
            S_INIT: begin
                o_init_we = 1'b1;
                w_nextCnt = r_cnt + 1'b1;
                if (r_cnt == LAST_ADDR) begin
                    w_nextState = S_RUN;
                end
            end
            S_RUN: begin
                w_nextState = S_RUN;
            end
            default: begin
                w_nextState = S_INIT;
            end
        endcase
    end

    assign o_init_done = (r_state == S_RUN);

endmodule

// File: rtl/ram_dp_init.sv
// Dual-port cell RAM with byte enables, post-reset init sweep, write-first collision
// bypass and read-valid pipeline. Define RAM_OUT_REG_EN for an extra output register.
module ram_dp_init
    import ram_dp_init_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 6,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    BYTE_W     = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    localparam int                   NUM_BE     = num_be(DATA_WIDTH, BYTE_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [NUM_BE-1:0]     wr_be,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_initWe;
    logic [ADDR_WIDTH-1:0] w_initAddr;
    logic                  w_initDone;

    logic                  w_wrAcc;
    logic                  w_rdAcc;
    logic                  w_memWe;
    logic [ADDR_WIDTH-1:0] w_memAddr;
    logic [DATA_WIDTH-1:0] w_memData;
    logic [NUM_BE-1:0]     w_memBe;

    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_rdMerged;

    logic [DATA_WIDTH-1:0] r_rdData1;
    logic                  r_rdValid1;

    ram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_initCtrl (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_init_we   (w_initWe),
        .o_init_addr (w_initAddr),
        .o_init_done (w_initDone)
    );

    // User traffic is only honoured once the sweep has finished.
    assign w_wrAcc = wr_en & w_initDone;
    assign w_rdAcc = rd_en & w_initDone;

    assign w_memWe   = w_initWe | w_wrAcc;
    assign w_memAddr = w_initWe ? w_initAddr : wr_addr;
    assign w_memData = w_initWe ? INIT_VALUE : wr_data;
    assign w_memBe   = w_initWe ? {NUM_BE{1'b1}} : wr_be;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BE; i++) begin
            if (w_memWe && w_memBe[i]) begin
                r_mem[w_memAddr][i*BYTE_W +: BYTE_W] <= w_memData[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Write-first: a same-cycle write to the read address overrides its enabled lanes.
    assign w_collide = w_wrAcc && (wr_addr == rd_addr);

    always_comb begin
        w_rdMerged = r_mem[rd_addr];
        for (int i = 0; i < NUM_BE; i++) begin
            if (w_collide && wr_be[i]) begin
                w_rdMerged[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData1  <= '0;
            r_rdValid1 <= 1'b0;
        end else begin
            r_rdValid1 <= w_rdAcc;
            if (w_rdAcc) begin
                r_rdData1 <= w_rdMerged;
            end
        end
    end

`ifdef RAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0] r_rdData2;
    logic                  r_rdValid2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdData2  <= '0;
            r_rdValid2 <= 1'b0;
        end else begin
            r_rdValid2 <= r_rdValid1;
            if (r_rdValid1) begin
                r_rdData2 <= r_rdData1;
            end
        end
    end

    assign rd_data  = r_rdData2;
    assign rd_valid = r_rdValid2;
`else
    assign rd_data  = r_rdData1;
    assign rd_valid = r_rdValid1;
`endif

    assign init_done = w_initDone;

endmodule

// File: tb/tb_ram_dp_init.sv
// Scoreboard bench for ram_dp_init (32-bit words, 4 byte lanes, 64 entries).
// Works with or without RAM_OUT_REG_EN.
module tb_ram_dp_init;

    localparam int          AW    = 6;
    localparam int          DW    = 32;
    localparam int          NBE   = 4;
    localparam int          DEPTH = 64;
    localparam logic [31:0] INITV = 32'hA5A5A5A5;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NBE-1:0] wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          init_done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] expQ [$];
    int          sinceRelease = 0;
    bit          expDone = 1'b0;

    ram_dp_init #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BYTE_W     (8),
        .INIT_VALUE (INITV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference memory is updated at the edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [NBE-1:0] be, input logic re, input logic [AW-1:0] ra);
        logic [DW-1:0] e;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        if (expDone) begin
            if (re) begin
                e = model[ra];
                if (we && wa == ra) begin
                    for (int i = 0; i < NBE; i++) begin
                        if (be[i]) e[8*i +: 8] = wd[8*i +: 8];
                    end
                end
                expQ.push_back(e);
            end
            if (we) begin
                for (int i = 0; i < NBE; i++) begin
                    if (be[i]) model[wa][8*i +: 8] = wd[8*i +: 8];
                end
            end
        end
        sinceRelease++;
        if (sinceRelease >= DEPTH) expDone = 1'b1;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic resetDut();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        expQ.delete();
        #1;
        checkOutput("reset rd_valid", {31'b0, rd_valid}, 32'd0);
        checkOutput("reset init_done", {31'b0, init_done}, 32'd0);
        checkOutput("reset rd_data", rd_data, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n        = 1'b1;
        sinceRelease = 0;
        expDone      = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = INITV;
    endtask

    task automatic checkSweep(input int trafficAt);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("sweep init_done low", {31'b0, init_done}, 32'd0);
            if (i == trafficAt)
                applyStimulus(1'b1, AW'(i), 32'hFFFFFFFF, 4'hF, 1'b1, AW'(i));
            else
                idle();
        end
        checkOutput("init_done after sweep", {31'b0, init_done}, 32'd1);
    endtask

    task automatic readAll();
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a));
        repeat (3) idle();
    endtask

    task automatic randomTraffic(input int n);
        repeat (n) begin
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                          NBE'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        end
        repeat (3) idle();
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: every rd_valid pulse must match the oldest expected read.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rd_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected rd_valid: got data %h, expected no read at %0t", rd_data, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("rd_data", rd_data, e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        @(posedge clk);
        #1;

        // Sweep with traffic attempted at cycle 10, then every address reads INITV.
        resetDut();
        checkSweep(10);
        readAll();

        // Byte-lane write and read latency.
        applyStimulus(1'b1, 6'd5, 32'h11223344, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 6'd5, 32'hFFFFFFFF, 4'b0010, 1'b0, '0);
        idle();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5);
`ifdef RAM_OUT_REG_EN
        checkOutput("latency valid early", {31'b0, rd_valid}, 32'd0);
        idle();
`endif
        checkOutput("latency valid", {31'b0, rd_valid}, 32'd1);
        checkOutput("be merge data", rd_data, 32'h1122FF44);
        idle();
        checkOutput("valid falls", {31'b0, rd_valid}, 32'd0);
        checkOutput("rd_data holds", rd_data, 32'h1122FF44);

        // Write-first collision on addr 7.
        applyStimulus(1'b1, 6'd7, 32'h0, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 6'd7, 32'hDEADBEEF, 4'b1100, 1'b1, 6'd7);
`ifdef RAM_OUT_REG_EN
        idle();
`endif
        checkOutput("collision data", rd_data, 32'hDEAD0000);
        repeat (2) idle();

        randomTraffic(400);

        // Reset while a read is in flight.
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 6'd5);
`ifndef RAM_OUT_REG_EN
        checkOutput("pre-reset valid", {31'b0, rd_valid}, 32'd1);
`endif
        resetDut();

        // Reset again mid-sweep at cycle 30, then a full sweep from address 0.
        for (int i = 0; i < 30; i++) begin
            checkOutput("partial sweep init_done", {31'b0, init_done}, 32'd0);
            idle();
        end
        resetDut();
        checkSweep(-1);
        readAll();
        randomTraffic(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
